// File: rtl/dram_resp_orderer_if.sv
// Shared request/response payload types and the channel-side bus bundle for dram_resp_orderer.
package dram_resp_orderer_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  // Request toward a DRAM channel; valid is the MSB.
  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } MemReq;

  // Read response; valid is the MSB so the payload is the low bits.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } MemResp;
endpackage

interface dram_resp_orderer_if;
  import dram_resp_orderer_pkg::*;

  MemReq  mem_req_c0_in;
  logic   mem_req_grant_c0_out;
  MemReq  mem_req_c1_in;
  logic   mem_req_grant_c1_out;
  MemReq  mem_req_c0_out;
  logic   mem_req_grant_c0_in;
  MemReq  mem_req_c1_out;
  logic   mem_req_grant_c1_in;
  MemResp mem_resp_c0_in;
  logic   mem_resp_grant_c0_out;
  MemResp mem_resp_c1_in;
  logic   mem_resp_grant_c1_out;
  MemResp mem_resp_out;
  logic   mem_resp_grant_in;
  logic   err_out;

  modport slave (
    input  mem_req_c0_in, mem_req_c1_in, mem_req_grant_c0_in, mem_req_grant_c1_in,
    input  mem_resp_c0_in, mem_resp_c1_in, mem_resp_grant_in,
    output mem_req_grant_c0_out, mem_req_grant_c1_out, mem_req_c0_out, mem_req_c1_out,
    output mem_resp_grant_c0_out, mem_resp_grant_c1_out, mem_resp_out, err_out
  );

  modport master (
    output mem_req_c0_in, mem_req_c1_in, mem_req_grant_c0_in, mem_req_grant_c1_in,
    output mem_resp_c0_in, mem_resp_c1_in, mem_resp_grant_in,
    input  mem_req_grant_c0_out, mem_req_grant_c1_out, mem_req_c0_out, mem_req_c1_out,
    input  mem_resp_grant_c0_out, mem_resp_grant_c1_out, mem_resp_out, err_out
  );
endinterface

// File: rtl/dram_resp_orderer.sv
// Restores issue order of read responses coming back from two DRAM channels.
module dram_resp_orderer #(
  parameter int unsigned LOG_ORDER_DEPTH = 9,
  parameter int unsigned LOG_RESP_DEPTH  = 6
) (
  input logic                clk,
  input logic                rst,
  dram_resp_orderer_if.slave bus
);
  import dram_resp_orderer_pkg::*;

  localparam int unsigned ORDER_DEPTH = 1 << LOG_ORDER_DEPTH;
  localparam int unsigned RESP_DEPTH  = 1 << LOG_RESP_DEPTH;
  localparam int unsigned RESP_W      = $bits(MemResp) - 1;
  localparam int unsigned OCNT_W      = LOG_ORDER_DEPTH + 1;
  localparam int unsigned RCNT_W      = LOG_RESP_DEPTH + 1;

  logic                       r_ord_mem [ORDER_DEPTH];
  logic [LOG_ORDER_DEPTH-1:0] r_ord_wptr;
  logic [LOG_ORDER_DEPTH-1:0] r_ord_rptr;
  logic [OCNT_W-1:0]          r_ord_cnt;
  logic [RESP_W-1:0]          r_rq_mem [2][RESP_DEPTH];
  logic [LOG_RESP_DEPTH-1:0]  r_rq_wptr [2];
  logic [LOG_RESP_DEPTH-1:0]  r_rq_rptr [2];
  logic [RCNT_W-1:0]          r_rq_cnt [2];
  logic [RCNT_W-1:0]          r_out [2];
  logic                       r_err;

  MemReq        w_req [2];
  MemResp       w_resp [2];
  logic [1:0]   w_gnt_in;
  logic [1:0]   w_rd;
  logic [1:0]   w_allow;
  logic [1:0]   w_acc;
  logic [1:0]   w_push;
  logic [1:0]   w_unexp;
  logic [1:0]   w_pop;
  logic         w_ord_full;
  logic         w_enq;
  logic         w_head;
  logic         w_out_valid;
  logic         w_deq;

  assign w_req[0]    = bus.mem_req_c0_in;
  assign w_req[1]    = bus.mem_req_c1_in;
  assign w_resp[0]   = bus.mem_resp_c0_in;
  assign w_resp[1]   = bus.mem_resp_c1_in;
  assign w_gnt_in    = {bus.mem_req_grant_c1_in, bus.mem_req_grant_c0_in};

  // Read admission: order-tag space, per-channel credit, channel 0 wins same-cycle reads.
  always_comb begin
    w_ord_full = (r_ord_cnt == OCNT_W'(ORDER_DEPTH));
    for (int n = 0; n < 2; n++) begin
      w_rd[n]     = w_req[n].valid && !w_req[n].is_write;
      w_unexp[n]  = w_resp[n].valid && (r_out[n] == r_rq_cnt[n]);
      w_push[n]   = w_resp[n].valid && (r_out[n] != r_rq_cnt[n]);
    end
    w_allow[0] = !w_rd[0] || (!w_ord_full && (r_out[0] < RCNT_W'(RESP_DEPTH)));
    w_allow[1] = !w_rd[1] || (!w_ord_full && (r_out[1] < RCNT_W'(RESP_DEPTH)) && !w_rd[0]);
    w_acc      = w_rd & w_allow & w_gnt_in;
    w_enq      = |w_acc;
    w_head     = r_ord_mem[r_ord_rptr];
    w_out_valid = !rst && (r_ord_cnt != '0) && (r_rq_cnt[w_head] != '0);
    w_deq      = w_out_valid && bus.mem_resp_grant_in;
    w_pop      = {w_deq && w_head, w_deq && !w_head};
  end

  // Bus outputs; every valid/grant is held low while in reset.
  always_comb begin
    bus.mem_req_c0_out        = bus.mem_req_c0_in;
    bus.mem_req_c0_out.valid  = bus.mem_req_c0_in.valid && w_allow[0] && !rst;
    bus.mem_req_c1_out        = bus.mem_req_c1_in;
    bus.mem_req_c1_out.valid  = bus.mem_req_c1_in.valid && w_allow[1] && !rst;
    bus.mem_req_grant_c0_out  = w_gnt_in[0] && w_allow[0] && !rst;
    bus.mem_req_grant_c1_out  = w_gnt_in[1] && w_allow[1] && !rst;
    bus.mem_resp_grant_c0_out = w_resp[0].valid && !rst;
    bus.mem_resp_grant_c1_out = w_resp[1].valid && !rst;
    bus.mem_resp_out          = MemResp'({w_out_valid, r_rq_mem[w_head][r_rq_rptr[w_head]]});
    bus.err_out               = r_err && !rst;
  end

  // Storage arrays: order tags and per-channel response payloads.
  always_ff @(posedge clk) begin
    if (w_enq) r_ord_mem[r_ord_wptr] <= w_acc[1];
    for (int n = 0; n < 2; n++) begin
      if (w_push[n]) r_rq_mem[n][r_rq_wptr[n]] <= w_resp[n][RESP_W-1:0];
    end
  end

  // Pointers, occupancy, outstanding credits and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ord_wptr <= '0;
      r_ord_rptr <= '0;
      r_ord_cnt  <= '0;
      r_err      <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        r_rq_wptr[n] <= '0;
        r_rq_rptr[n] <= '0;
        r_rq_cnt[n]  <= '0;
        r_out[n]     <= '0;
      end
    end else begin
      if (w_enq) r_ord_wptr <= r_ord_wptr + LOG_ORDER_DEPTH'(1);
      if (w_deq) r_ord_rptr <= r_ord_rptr + LOG_ORDER_DEPTH'(1);
      r_ord_cnt <= r_ord_cnt + OCNT_W'(w_enq) - OCNT_W'(w_deq);
      if (|w_unexp) r_err <= 1'b1;
      for (int n = 0; n < 2; n++) begin
        if (w_push[n]) r_rq_wptr[n] <= r_rq_wptr[n] + LOG_RESP_DEPTH'(1);
        if (w_pop[n])  r_rq_rptr[n] <= r_rq_rptr[n] + LOG_RESP_DEPTH'(1);
        r_rq_cnt[n] <= r_rq_cnt[n] + RCNT_W'(w_push[n]) - RCNT_W'(w_pop[n]);
        r_out[n]    <= r_out[n] + RCNT_W'(w_acc[n]) - RCNT_W'(w_pop[n]);
      end
    end
  end
endmodule

// File: tb/tb_dram_resp_orderer.sv
// Directed bench for dram_resp_orderer: admission table plus ordering/credit/reset sequences.
module tb_dram_resp_orderer;
  import dram_resp_orderer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  dram_resp_orderer_if bus();

  dram_resp_orderer #(.LOG_ORDER_DEPTH(9), .LOG_RESP_DEPTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic  v0, w0, v1, w1, g0, g1;
    logic  eg0, eg1, ev0, ev1;
    string name;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic MemReq mk_req(input logic v, input logic w, input logic [31:0] a);
    MemReq r;
    r.valid = v;
    r.is_write = w;
    r.addr = a;
    r.wdata = 32'h0;
    return r;
  endfunction

  function automatic MemResp mk_resp(input logic v, input logic [31:0] d);
    MemResp r;
    r.valid = v;
    r.data = d;
    return r;
  endfunction

  task automatic idle_req();
    bus.mem_req_c0_in = mk_req(1'b0, 1'b0, 32'h0);
    bus.mem_req_c1_in = mk_req(1'b0, 1'b0, 32'h0);
  endtask

  task automatic idle_resp();
    bus.mem_resp_c0_in = mk_resp(1'b0, 32'h0);
    bus.mem_resp_c1_in = mk_resp(1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  function automatic logic [63:0] out_word();
    return {31'h0, bus.mem_resp_out.valid, bus.mem_resp_out.data};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int miss;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "c0_rd"};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "c1_rd"};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "both_rd"};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "c0wr_c1rd"};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "c0rd_c1wr"};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "c0rd_nogrant"};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "both_rd_c0stall"};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "c1rd_nogrant"};

    rst = 1'b1;
    idle_req();
    idle_resp();
    bus.mem_req_grant_c0_in = 1'b1;
    bus.mem_req_grant_c1_in = 1'b1;
    bus.mem_resp_grant_in = 1'b1;

    // Reset behaviour: grants forced low while stimulus is present.
    cyc();
    bus.mem_req_c0_in = mk_req(1'b1, 1'b0, 32'h10);
    bus.mem_resp_c0_in = mk_resp(1'b1, 32'h55);
    #1;
    check("rst_req_grant", 64'(bus.mem_req_grant_c0_out), 64'd0);
    check("rst_req_valid", 64'(bus.mem_req_c0_out.valid), 64'd0);
    check("rst_resp_grant", 64'(bus.mem_resp_grant_c0_out), 64'd0);
    check("rst_out_valid", 64'(bus.mem_resp_out.valid), 64'd0);
    check("rst_err", 64'(bus.err_out), 64'd0);
    idle_req();
    idle_resp();
    cyc();
    rst = 1'b0;

    // Admission table from the empty state; reset after each row to clear credits.
    for (int i = 0; i < 8; i++) begin
      cyc();
      bus.mem_req_c0_in = mk_req(tbl[i].v0, tbl[i].w0, 32'h100);
      bus.mem_req_c1_in = mk_req(tbl[i].v1, tbl[i].w1, 32'h200);
      bus.mem_req_grant_c0_in = tbl[i].g0;
      bus.mem_req_grant_c1_in = tbl[i].g1;
      #1;
      check({tbl[i].name, "_gnt"}, 64'({bus.mem_req_grant_c0_out, bus.mem_req_grant_c1_out}),
            64'({tbl[i].eg0, tbl[i].eg1}));
      check({tbl[i].name, "_vld"}, 64'({bus.mem_req_c0_out.valid, bus.mem_req_c1_out.valid}),
            64'({tbl[i].ev0, tbl[i].ev1}));
      cyc();
      idle_req();
      bus.mem_req_grant_c0_in = 1'b1;
      bus.mem_req_grant_c1_in = 1'b1;
      do_reset();
    end

    // Cross-channel ordering: c1 answers first, A must still lead.
    cyc();
    bus.mem_req_c0_in = mk_req(1'b1, 1'b0, 32'hA);
    cyc();
    bus.mem_req_c0_in = mk_req(1'b0, 1'b0, 32'h0);
    bus.mem_req_c1_in = mk_req(1'b1, 1'b0, 32'hB);
    cyc();
    idle_req();
    cyc();
    bus.mem_resp_c1_in = mk_resp(1'b1, 32'hB0B0);
    #1;
    check("ord_c1_resp_grant", 64'(bus.mem_resp_grant_c1_out), 64'd1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      idle_resp();
      #1;
      check("ord_no_b_first", 64'(bus.mem_resp_out.valid), 64'd0);
    end
    cyc();
    bus.mem_resp_c0_in = mk_resp(1'b1, 32'hA0A0);
    #1;
    check("ord_same_cycle", 64'(bus.mem_resp_out.valid), 64'd0);
    cyc();
    idle_resp();
    #1;
    check("ord_a", out_word(), {31'h0, 1'b1, 32'hA0A0});
    cyc();
    #1;
    check("ord_b", out_word(), {31'h0, 1'b1, 32'hB0B0});
    cyc();
    #1;
    check("ord_drained", 64'(bus.mem_resp_out.valid), 64'd0);
    check("ord_err", 64'(bus.err_out), 64'd0);
    do_reset();

    // Credit limit on channel 0: 64 reads then a stall; writes still pass.
    miss = 0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      bus.mem_req_c0_in = mk_req(1'b1, 1'b0, 32'(i));
      #1;
      if (bus.mem_req_grant_c0_out !== 1'b1) miss++;
    end
    check("credit_fill_misses", 64'(miss), 64'd0);
    cyc();
    bus.mem_req_c0_in = mk_req(1'b1, 1'b0, 32'h40);
    #1;
    check("credit_65th_grant", 64'(bus.mem_req_grant_c0_out), 64'd0);
    check("credit_65th_valid", 64'(bus.mem_req_c0_out.valid), 64'd0);
    cyc();
    bus.mem_req_c0_in = mk_req(1'b1, 1'b1, 32'h41);
    #1;
    check("credit_write_grant", 64'(bus.mem_req_grant_c0_out), 64'd1);
    cyc();
    idle_req();
    bus.mem_resp_c0_in = mk_resp(1'b1, 32'h1234);
    #1;
    check("credit_resp_grant", 64'(bus.mem_resp_grant_c0_out), 64'd1);
    cyc();
    idle_resp();
    bus.mem_req_c0_in = mk_req(1'b1, 1'b0, 32'h42);
    #1;
    check("credit_still_full", 64'(bus.mem_req_grant_c0_out), 64'd0);
    check("credit_first_data", out_word(), {31'h0, 1'b1, 32'h1234});
    cyc();
    #1;
    check("credit_regranted", 64'(bus.mem_req_grant_c0_out), 64'd1);
    cyc();
    idle_req();
    #1;
    check("credit_no_more_out", 64'(bus.mem_resp_out.valid), 64'd0);
    do_reset();

    // Backpressure hold with a write interleaved among four reads.
    bus.mem_resp_grant_in = 1'b0;
    cyc(); bus.mem_req_c0_in = mk_req(1'b1, 1'b0, 32'h0);
    cyc(); bus.mem_req_c0_in = mk_req(1'b1, 1'b1, 32'h1);
    cyc(); bus.mem_req_c0_in = mk_req(1'b0, 1'b0, 32'h0);
           bus.mem_req_c1_in = mk_req(1'b1, 1'b0, 32'h2);
    cyc(); bus.mem_req_c0_in = mk_req(1'b1, 1'b0, 32'h3);
           bus.mem_req_c1_in = mk_req(1'b0, 1'b0, 32'h0);
    cyc(); bus.mem_req_c0_in = mk_req(1'b0, 1'b0, 32'h0);
           bus.mem_req_c1_in = mk_req(1'b1, 1'b0, 32'h4);
    cyc(); idle_req();
           bus.mem_resp_c1_in = mk_resp(1'b1, 32'hD1);
    cyc(); bus.mem_resp_c1_in = mk_resp(1'b1, 32'hD3);
           bus.mem_resp_c0_in = mk_resp(1'b1, 32'hD0);
    cyc(); bus.mem_resp_c1_in = mk_resp(1'b0, 32'h0);
           bus.mem_resp_c0_in = mk_resp(1'b1, 32'hD2);
    cyc(); idle_resp();
    miss = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      #1;
      if (out_word() !== {31'h0, 1'b1, 32'hD0}) miss++;
    end
    check("hold_stable_misses", 64'(miss), 64'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      bus.mem_resp_grant_in = 1'b1;
      #1;
      check($sformatf("stream_%0d", k), out_word(), {31'h0, 1'b1, 32'hD0 + 32'(k)});
    end
    cyc();
    #1;
    check("stream_drained", 64'(bus.mem_resp_out.valid), 64'd0);
    do_reset();

    // Stale responses after a mid-flight reset are dropped and flagged.
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.mem_req_c0_in = mk_req(1'b1, 1'b0, 32'(i));
    end
    cyc();
    idle_req();
    rst = 1'b1;
    #1;
    check("stale_rst_err", 64'(bus.err_out), 64'd0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.mem_resp_c0_in = mk_resp(1'b1, 32'hE0 + 32'(i));
      #1;
      check($sformatf("stale_grant_%0d", i), 64'(bus.mem_resp_grant_c0_out), 64'd1);
      cyc();
      idle_resp();
      #1;
      check($sformatf("stale_valid_%0d", i), 64'(bus.mem_resp_out.valid), 64'd0);
      check($sformatf("stale_err_%0d", i), 64'(bus.err_out), 64'd1);
      cyc();
    end
    repeat (3) cyc();
    check("stale_err_sticky", 64'(bus.err_out), 64'd1);
    do_reset();
    #1;
    check("err_cleared", 64'(bus.err_out), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
